// File: rtl/rr_logb_pkg.sv
// Shared types, constants and helpers for the logb marshaller family.
package rr_logb_pkg;

    localparam int RR_LOGB_MAX_FANIN = 16;

    function automatic int rr_clog2p1(input int x);
        return $clog2(x + 1);
    endfunction

    localparam int RR_W_MAX_DEF = 64;
    localparam int RR_LEN_W_DEF = rr_clog2p1(RR_W_MAX_DEF);

    typedef logic [RR_LEN_W_DEF-1:0] rr_len_t;

    // Per-channel fragment header at the default fragment width.
    typedef struct packed {
        logic    valid;
        rr_len_t len;
    } rr_frag_hdr_t;

endpackage

// File: rtl/rr_logb_elastic_stage.sv
// One valid/ready pipeline register; data only reloads on a valid beat.
module rr_logb_elastic_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/rr_logb_marshaller_n.sv
// N-way logb fragment compactor, two elastic stages (S1 capture, S2 packed).
// Optional RR_MARSHALLER_STATS_EN adds beat/stall/bit counters.
module rr_logb_marshaller_n
    import rr_logb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int W_MAX     = 64,
    parameter int LEN_W     = rr_clog2p1(W_MAX),
    parameter int OUT_W     = N_IN * W_MAX,
    parameter int OUT_LEN_W = rr_clog2p1(OUT_W),
    parameter int ZERO_PAD  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*LEN_W-1:0] in_len,
    input  logic [N_IN*W_MAX-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_data,
    output logic [OUT_LEN_W-1:0]  out_len,
    output logic [N_IN-1:0]       out_mask,
    input  logic                  out_ready,
`ifdef RR_MARSHALLER_STATS_EN
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_stalls,
    output logic [47:0]           stat_bits,
`endif
    output logic                  err_len_ovf
);

    localparam int S1_W = N_IN + N_IN*LEN_W + N_IN*W_MAX;
    localparam int S2_W = OUT_W + OUT_LEN_W + N_IN;

    logic [N_IN*LEN_W-1:0] cap_len;
    logic [N_IN*W_MAX-1:0] cap_data;
    logic                  ovf_hit;
    logic                  accept;

    // Clamp lengths and clear bits above each fragment so the OR-merge stays clean.
    always_comb begin
        cap_len  = '0;
        cap_data = '0;
        ovf_hit  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_valid[i]) begin
                if (in_len[i*LEN_W +: LEN_W] > LEN_W'(W_MAX)) begin
                    cap_len[i*LEN_W +: LEN_W] = LEN_W'(W_MAX);
                    ovf_hit = 1'b1;
                end else begin
                    cap_len[i*LEN_W +: LEN_W] = in_len[i*LEN_W +: LEN_W];
                end
            end
            for (int b = 0; b < W_MAX; b++) begin
                cap_data[i*W_MAX + b] = in_data[i*W_MAX + b]
                                        & (LEN_W'(b) < cap_len[i*LEN_W +: LEN_W]);
            end
        end
    end

    assign accept = (|in_valid) && in_ready;

    logic                  s1_v;
    logic                  s2_ready;
    logic [S1_W-1:0]       s1_q;
    logic [N_IN-1:0]       s1_mask;
    logic [N_IN*LEN_W-1:0] s1_len;
    logic [N_IN*W_MAX-1:0] s1_data;

    rr_logb_elastic_stage #(.DATA_W(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (|in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_valid, cap_len, cap_data}),
        .out_valid (s1_v),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    assign s1_mask = s1_q[S1_W-1 -: N_IN];
    assign s1_len  = s1_q[N_IN*W_MAX +: N_IN*LEN_W];
    assign s1_data = s1_q[0 +: N_IN*W_MAX];

    logic [OUT_W-1:0]     pk_raw;
    logic [OUT_W-1:0]     pk_data;
    logic [OUT_LEN_W-1:0] pk_len;

    // Running prefix sum doubles as the shift offset for the next channel.
    always_comb begin
        pk_raw = '0;
        pk_len = '0;
        for (int i = 0; i < N_IN; i++) begin
            pk_raw = pk_raw | (OUT_W'(s1_data[i*W_MAX +: W_MAX]) << pk_len);
            pk_len = pk_len + OUT_LEN_W'(s1_len[i*LEN_W +: LEN_W]);
        end
    end

    generate
        if (ZERO_PAD != 0) begin : g_zero_pad
            always_comb begin
                pk_data = '0;
                for (int b = 0; b < OUT_W; b++) begin
                    pk_data[b] = pk_raw[b] & (OUT_LEN_W'(b) < pk_len);
                end
            end
        end else begin : g_no_pad
            assign pk_data = pk_raw;
        end
    endgenerate

    logic [S2_W-1:0] s2_q;

    rr_logb_elastic_stage #(.DATA_W(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_v),
        .in_ready  (s2_ready),
        .in_data   ({pk_data, pk_len, s1_mask}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_data = s2_q[S2_W-1 -: OUT_W];
    assign out_len  = s2_q[N_IN +: OUT_LEN_W];
    assign out_mask = s2_q[0 +: N_IN];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_len_ovf <= 1'b0;
        end else if (accept && ovf_hit) begin
            err_len_ovf <= 1'b1;
        end
    end

`ifdef RR_MARSHALLER_STATS_EN
    logic [48:0] bits_sum;
    assign bits_sum = {1'b0, stat_bits} + 49'(out_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
            stat_bits   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                if (stat_beats != '1) begin
                    stat_beats <= stat_beats + 32'd1;
                end
                stat_bits <= bits_sum[48] ? '1 : bits_sum[47:0];
            end
            if (out_valid && !out_ready && stat_stalls != '1) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_logb_marshaller_n.sv
// Directed bench for rr_logb_marshaller_n at N_IN=4, W_MAX=8.
module tb_rr_logb_marshaller_n;

    localparam int N_IN      = 4;
    localparam int W_MAX     = 8;
    localparam int LEN_W     = 4;
    localparam int OUT_W     = 32;
    localparam int OUT_LEN_W = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN*LEN_W-1:0] in_len;
    logic [N_IN*W_MAX-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [OUT_W-1:0]      out_data;
    logic [OUT_LEN_W-1:0]  out_len;
    logic [N_IN-1:0]       out_mask;
    logic                  out_ready;
    logic                  err_len_ovf;
`ifdef RR_MARSHALLER_STATS_EN
    logic [31:0]           stat_beats;
    logic [31:0]           stat_stalls;
    logic [47:0]           stat_bits;
`endif

    always #5 clk = ~clk;

    rr_logb_marshaller_n #(
        .N_IN(N_IN), .W_MAX(W_MAX), .LEN_W(LEN_W),
        .OUT_W(OUT_W), .OUT_LEN_W(OUT_LEN_W), .ZERO_PAD(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_len     (in_len),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_len    (out_len),
        .out_mask   (out_mask),
        .out_ready  (out_ready),
`ifdef RR_MARSHALLER_STATS_EN
        .stat_beats (stat_beats),
        .stat_stalls(stat_stalls),
        .stat_bits  (stat_bits),
`endif
        .err_len_ovf(err_len_ovf)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] len;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [5:0]  exp_len;
        logic [3:0]  exp_mask;
        logic        exp_err;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Single beat through an empty pipe with out_ready held high.
    task automatic apply(input int idx, input vec_t v);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = v.valid; in_len = v.len; in_data = v.data;
        @(posedge clk); #1;
        in_valid = '0;
        @(negedge clk);
        chk($sformatf("v%0d early_valid", idx), 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d out_data", idx), 64'(out_data), 64'(v.exp_data));
        chk($sformatf("v%0d out_len", idx), 64'(out_len), 64'(v.exp_len));
        chk($sformatf("v%0d out_mask", idx), 64'(out_mask), 64'(v.exp_mask));
        chk($sformatf("v%0d err_len_ovf", idx), 64'(err_len_ovf), 64'(v.exp_err));
    endtask

    function automatic logic [31:0] bp_exp(input int k);
        logic [3:0] hi;
        logic [7:0] lo;
        hi = 4'(k + 1);
        lo = 8'(8'h10 + k);
        return {20'h0, hi, lo};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        int   k_acc, k_del, cyc, infl, max_infl;
        logic saw_low, stale;

        vt[0] = '{4'hF, 16'h8888, 32'hDDCCBBAA, 32'hDDCCBBAA, 6'd32, 4'hF, 1'b0};
        vt[1] = '{4'hA, 16'h8848, 32'h3CFF05FF, 32'h000003C5, 6'd12, 4'hA, 1'b0};
        vt[2] = '{4'h1, 16'h8883, 32'hFFFFFFFF, 32'h00000007, 6'd3,  4'h1, 1'b0};
        vt[3] = '{4'h6, 16'hF508, 32'hEE1FFF77, 32'h0000001F, 6'd5,  4'h6, 1'b0};
        vt[4] = '{4'hF, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 6'd0,  4'hF, 1'b0};
        vt[5] = '{4'h9, 16'h7881, 32'h7FAA5501, 32'h000000FF, 6'd8,  4'h9, 1'b0};
        vt[6] = '{4'hF, 16'h4321, 32'hFFFDFFFF, 32'h000003EF, 6'd10, 4'hF, 1'b0};
        vt[7] = '{4'h8, 16'h8000, 32'h81000000, 32'h00000081, 6'd8,  4'h8, 1'b0};
        vt[8] = '{4'h1, 16'h000C, 32'h000000FF, 32'h000000FF, 6'd8,  4'h1, 1'b1};
        vt[9] = '{4'h3, 16'h0084, 32'h0000A5FC, 32'h00000A5C, 6'd12, 4'h3, 1'b1};

        rst = 1'b1; in_valid = '0; in_len = '0; in_data = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_len", 64'(out_len), 64'd0);
        chk("reset out_mask", 64'(out_mask), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset err_len_ovf", 64'(err_len_ovf), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) apply(i, vt[i]);

        do_reset();
        @(negedge clk);
        chk("err cleared by rst", 64'(err_len_ovf), 64'd0);

        // Backpressure: 10 beats, out_ready low for cycles 3..7.
        k_acc = 0; k_del = 0; cyc = 0; max_infl = 0; saw_low = 1'b0;
        while (k_del < 10 && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc <= 7);
            if (k_acc < 10) begin
                in_valid = 4'b0011;
                in_len   = 16'h0048;
                in_data  = {16'h0, 8'hF0 | 8'(k_acc + 1), 8'(8'h10 + k_acc)};
            end else begin
                in_valid = '0;
            end
            @(negedge clk);
            infl = k_acc - k_del;
            if (infl > max_infl) max_infl = infl;
            if (out_valid) begin
                chk($sformatf("bp beat%0d data", k_del), 64'(out_data), 64'(bp_exp(k_del)));
                chk($sformatf("bp beat%0d len", k_del), 64'(out_len), 64'd12);
                chk($sformatf("bp beat%0d mask", k_del), 64'(out_mask), 64'h3);
                if (out_ready) k_del++;
            end
            if (!in_ready) begin
                saw_low = 1'b1;
                chk("bp in_ready low inflight", 64'(infl), 64'd2);
            end
            if (in_valid != '0 && in_ready) k_acc++;
            cyc++;
        end
        in_valid = '0;
        out_ready = 1'b1;
        chk("bp delivered", 64'(k_del), 64'd10);
        chk("bp accepted", 64'(k_acc), 64'd10);
        chk("bp max inflight", 64'(max_infl), 64'd2);
        chk("bp in_ready dropped", 64'(saw_low), 64'd1);

        // Reset with two beats in flight; a beat offered during rst must be ignored.
        do_reset();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 4'h1; in_len = 16'h0008; in_data = 32'h11;
        @(posedge clk); #1;
        in_data = 32'h22;
        @(posedge clk); #1;
        rst = 1'b1; in_data = 32'h33;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst out_len", 64'(out_len), 64'd0);
        chk("midrst out_mask", 64'(out_mask), 64'd0);
        chk("midrst out_data", 64'(out_data), 64'd0);
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("midrst no stale beat", 64'(stale), 64'd0);
        apply(10, vt[0]);

`ifdef RR_MARSHALLER_STATS_EN
        do_reset();
        @(negedge clk);
        chk("stats reset beats", 64'(stat_beats), 64'd0);
        chk("stats reset stalls", 64'(stat_stalls), 64'd0);
        chk("stats reset bits", 64'(stat_bits), 64'd0);
        begin
            int st_done;
            k_acc = 0; k_del = 0; cyc = 0; st_done = 0;
            while (k_del < 5 && cyc < 100) begin
                @(posedge clk); #1;
                if (out_valid && st_done < 3) begin
                    out_ready = 1'b0;
                    st_done++;
                end else begin
                    out_ready = 1'b1;
                end
                if (k_acc < 5) begin
                    in_valid = 4'hF; in_len = 16'h8888;
                    in_data  = 32'hA0B0C0D0 + 32'(k_acc);
                end else begin
                    in_valid = '0;
                end
                @(negedge clk);
                if (in_valid != '0 && in_ready) k_acc++;
                if (out_valid && out_ready) k_del++;
                cyc++;
            end
            @(posedge clk); #1;
            in_valid = '0; out_ready = 1'b1;
            @(negedge clk);
            chk("stats beats", 64'(stat_beats), 64'd5);
            chk("stats stalls", 64'(stat_stalls), 64'd3);
            chk("stats bits", 64'(stat_bits), 64'd160);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
